mac_seq: RTL and testbench
==========================

Name: mac_seq

Overview:
- Sequencer for one MAC accumulate/round datapath.
- On a start command it clears the accumulator and streams a programmed number of operand pairs into it under a valid/ready handshake.
- It waits out the MAC pipeline latency, then pulses the round stage's load strobe and captures the rounded N-bit result with its validity flag.
- It holds the result on a valid/ready output port until consumed. It sits between the host/DMA command interface and the MAC + round datapath.

Parameters:
- N, 16, datapath word width; round result width is N, accumulator/err width is 2*N.
- Q, 8, fractional bits. Not used internally; passed through for consistency with the datapath.
- LEN_W, 8, width of the term-count field.
- PIPE_LAT, 2, cycles from the last acc_en to accumulator settled (0 allowed).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe, sampled in IDLE only
- len  in  LEN_W  number of products to accumulate, sampled with start
- in_valid  in  1  upstream operand pair valid
- in_ready  out  1  sequencer accepts operand pair
- acc_clr  out  1  clear accumulator
- acc_en  out  1  accumulate the current operand pair (= in_valid & in_ready)
- qsload  out  1  round-stage load strobe
- rvalid  in  1  round stage: result valid (no sum/mult/round overflow)
- res  in  N  round stage result
- err  in  2*N  round stage residual; bit 2*N-1 = accumulator sign
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  N  captured result
- out_ovf  out  1  captured result invalid (rvalid was 0)
- busy  out  1  high in every state except IDLE

Behaviour:
- **Reset (async, rst=1):**
  - state=IDLE; term and drain counters = 0.
  - out_data = 0, out_ovf = 0, out_valid = 0.
  - in_ready, acc_en, acc_clr, qsload, busy = 0.
  - Reset mid-operation aborts immediately; no partial result is emitted.
- **States:** IDLE, CLR, ACC, DRAIN, ROUND, OUT. All outputs are decoded from registered state; acc_en is combinational from in_valid.
- **IDLE:**
  - start=1 & len!=0: latch len, cnt=0, go to CLR.
  - start with len==0: ignored.
  - start in any other state: ignored (not queued).
- **CLR:** acc_clr=1 for exactly one cycle; in_ready=0. Go to ACC. A clear never coincides with an accumulate.
- **ACC:**
  - in_ready=1; each handshake increments cnt.
  - Handshake with cnt==len-1: go to DRAIN, load drain counter = PIPE_LAT.
  - in_valid gaps stall indefinitely; no timeout.
- **DRAIN:**
  - in_ready=0; decrement each cycle; go to ROUND when it reads 0.
  - PIPE_LAT=0 passes through DRAIN in 1 cycle.
- **ROUND:**
  - qsload=1 for one cycle.
  - Same cycle: out_data<=res, out_ovf<=~rvalid.
  - Go to OUT.
- **OUT:**
  - out_valid=1; out_data/out_ovf stable until out_ready=1 in a cycle.
  - Then go to IDLE (out_valid low next cycle). out_ready ignored outside OUT.
- **Latency:** start to first in_ready = 2 cycles. Last handshake to out_valid = PIPE_LAT+3 cycles.
- **len = 2^LEN_W-1:** full count; cnt never wraps.

Optional Feature:
- Macro: MAC_SEQ_SAT_EN.
- Defined: when ROUND captures rvalid=0, out_data saturates:
  - err[2*N-1]=0 gives 0x7FFF (N=16, max positive);
  - err[2*N-1]=1 gives 0x8000 (min negative).
  - out_ovf is still set.
- Undefined: out_data = res unmodified; err port unused.

Test Plan:
- Reset mid-ACC after 3 of 5 terms -> next cycle busy=0, in_ready=0, out_valid=0; no qsload pulse afterward.
- start, len=4, in_valid held 1, PIPE_LAT=2 -> acc_clr in cycle 1, acc_en in cycles 2-5, qsload in cycle 9, out_valid from cycle 10.
- len=3 with in_valid toggling 1,0,1,0,1 -> exactly 3 acc_en pulses; qsload 4 cycles after the third; start pulsed mid-ACC has no effect.
- ROUND with res=0x1234, rvalid=1, out_ready=0 for 5 cycles -> out_data=0x1234 and out_ovf=0 held 5 cycles; IDLE the cycle after out_ready=1.
- start with len=0 -> busy stays 0, no acc_clr.
- rvalid=0, err[31]=1, res=0x0F00 -> out_ovf=1; out_data=0x8000 with MAC_SEQ_SAT_EN, 0x0F00 without.

Source files
------------

// File: rtl/mac_seq_if.sv
// Command, operand handshake, datapath control and result port of the MAC sequencer.
// master = sequencer side, slave = host/datapath side.
interface mac_seq_if #(
    parameter int N     = 16,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic             acc_clr;
    logic             acc_en;
    logic             qsload;
    logic             rvalid;
    logic [N-1:0]     res;
    logic [2*N-1:0]   err;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             out_ovf;
    logic             busy;

    modport master (
        input  start, len, in_valid, rvalid, res, err, out_ready,
        output in_ready, acc_clr, acc_en, qsload, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        output start, len, in_valid, rvalid, res, err, out_ready,
        input  in_ready, acc_clr, acc_en, qsload, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/mac_seq.sv
// Sequencer for one MAC accumulate/round pass: clear, stream len terms, drain, round, hand off.
// Build option MAC_SEQ_SAT_EN: on a round overflow, saturate out_data from the accumulator sign.
//
// state   | meaning
// IDLE    | waiting for start with nonzero len
// CLR     | one-cycle accumulator clear
// ACC     | accepting operand pairs until len terms taken
// DRAIN   | waiting out the MAC pipeline latency
// ROUND   | round-stage load strobe, capture result
// OUT     | result held until downstream accepts
module mac_seq #(
    parameter int N        = 16,
    parameter int Q        = 8,
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 2
) (
    input logic       clk,
    input logic       rst,
    mac_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_ACC, S_DRAIN, S_ROUND, S_OUT
    } state_t;

    localparam int DRAIN_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_LAT);
    // Q only documents the datapath's fixed-point format.
    localparam int unused_q = Q;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [DRAIN_W-1:0] drain;
    logic [N-1:0]     out_data_q;
    logic             out_ovf_q;
    logic [N-1:0]     res_cap;
    logic             handshake;
    logic             last_term;
    logic             cmd_ok;

    assign handshake = bus.in_valid & bus.in_ready;
    assign last_term = handshake && (cnt == (len_q - LEN_W'(1)));
    assign cmd_ok    = bus.start && (bus.len != '0);

    assign bus.in_ready  = (state == S_ACC);
    assign bus.acc_clr   = (state == S_CLR);
    assign bus.acc_en    = handshake;
    assign bus.qsload    = (state == S_ROUND);
    assign bus.out_valid = (state == S_OUT);
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

`ifdef MAC_SEQ_SAT_EN
    logic unused_err_low;
    assign unused_err_low = ^bus.err[2*N-2:0];

    always_comb begin
        res_cap = bus.res;
        if (!bus.rvalid)
            res_cap = bus.err[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`else
    logic unused_err;
    assign unused_err = ^bus.err;
    assign res_cap    = bus.res;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_ok) state_nxt = S_CLR;
            S_CLR:   state_nxt = S_ACC;
            S_ACC:   if (last_term) state_nxt = S_DRAIN;
            S_DRAIN: if (drain == '0) state_nxt = S_ROUND;
            S_ROUND: state_nxt = S_OUT;
            S_OUT:   if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            cnt        <= '0;
            drain      <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && cmd_ok) begin
                len_q <= bus.len;
                cnt   <= '0;
            end else if (handshake) begin
                cnt <= cnt + LEN_W'(1);
            end

            if (last_term)
                drain <= DRAIN_INIT;
            else if (state == S_DRAIN && drain != '0)
                drain <= drain - DRAIN_W'(1);

            if (state == S_ROUND) begin
                out_data_q <= res_cap;
                out_ovf_q  <= ~bus.rvalid;
            end
        end
    end
endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: directed timing cases, a capture table and randomized commands
// checked against a transaction-level model (term count, latency, captured value).
module tb_mac_seq;
    localparam int N        = 16;
    localparam int Q        = 8;
    localparam int LEN_W    = 8;
    localparam int PIPE_LAT = 2;
`ifdef MAC_SEQ_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    mac_seq_if #(.N(N), .LEN_W(LEN_W)) bus ();

    mac_seq #(.N(N), .Q(Q), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] res;
        logic         rv;
        logic         sgn;
        int           hold;
        logic [N-1:0] exp_data;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a round overflow either passes res through or clamps to the signed extreme
    // matching the accumulator sign.
    function automatic logic [N-1:0] model_data(input logic [N-1:0] r, input logic rv, input logic sgn);
        int max_pos;
        if (rv || !SAT_EN) return r;
        max_pos = (1 << (N - 1)) - 1;
        return sgn ? N'(max_pos + 1) : N'(max_pos);
    endfunction

    task automatic run_txn(input int l, input int vpct, input int hold,
                           input logic [N-1:0] r, input logic rv, input logic [2*N-1:0] e,
                           input bit poke,
                           output int first_hs, output int last_hs, output int q_cyc,
                           output int ov_cyc, output logic [N-1:0] cap_data, output logic cap_ovf);
        int cyc, hs, clr_n, clr_cyc, q_n, ov_n, idle_n, both_n, en_bad;
        bit done;
        logic [N-1:0] exp_d;
        cyc = 0; hs = 0; clr_n = 0; clr_cyc = -1; q_n = 0; ov_n = 0;
        idle_n = 0; both_n = 0; en_bad = 0; done = 1'b0;
        first_hs = -1; last_hs = -1; q_cyc = -1; ov_cyc = -1;
        cap_data = '0; cap_ovf = 1'b0;
        exp_d = model_data(r, rv, e[2*N-1]);

        @(posedge clk); #1;
        bus.start = 1'b1; bus.len = LEN_W'(l);
        bus.res = r; bus.rvalid = rv; bus.err = e;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = poke && (hs == 1);
            bus.len   = LEN_W'($urandom);
            if (vpct < 0) bus.in_valid = (cyc >= 2) && ((cyc % 2) == 0);
            else          bus.in_valid = ($urandom_range(0, 99) < vpct);
            bus.out_ready = (ov_n >= hold);
            #1;
            if (bus.busy !== 1'b1) idle_n++;
            if (bus.acc_en !== (bus.in_valid & bus.in_ready)) en_bad++;
            if (bus.acc_en && bus.acc_clr) both_n++;
            if (bus.acc_clr) begin clr_n++; clr_cyc = cyc; end
            if (bus.acc_en) begin
                hs++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            if (bus.qsload) begin q_n++; q_cyc = cyc; end
            if (bus.out_valid) begin
                if (ov_cyc < 0) begin
                    ov_cyc = cyc; cap_data = bus.out_data; cap_ovf = bus.out_ovf;
                end
                check("out_data", 64'(bus.out_data), 64'(exp_d));
                check("out_ovf", 64'(bus.out_ovf), 64'(!rv));
                ov_n++;
                if (bus.out_ready) done = 1'b1;
            end
        end
        check("txn_done", 64'(done), 64'(1));
        check("clr_once", 64'(clr_n), 64'(1));
        check("clr_cycle", 64'(clr_cyc), 64'(1));
        check("first_hs_not_before_2", 64'(first_hs >= 2), 64'(1));
        check("term_count", 64'(hs), 64'(l));
        check("qsload_once", 64'(q_n), 64'(1));
        check("qsload_latency", 64'(q_cyc - last_hs), 64'(PIPE_LAT + 2));
        check("out_valid_latency", 64'(ov_cyc - last_hs), 64'(PIPE_LAT + 3));
        check("out_hold_cycles", 64'(ov_n), 64'(hold + 1));
        check("busy_gap", 64'(idle_n), 64'(0));
        check("clr_en_overlap", 64'(both_n), 64'(0));
        check("acc_en_decode", 64'(en_bad), 64'(0));
        @(posedge clk); #1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        check("idle_after_out_busy", 64'(bus.busy), 64'(0));
        check("idle_after_out_valid", 64'(bus.out_valid), 64'(0));
    endtask

    initial begin
        int fh, lh, qc, oc, hs, bad;
        logic [N-1:0] cd;
        logic co;

        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        bus.rvalid = 1'b0; bus.res = '0; bus.err = '0;

        vecs[0] = '{res: 16'h1234, rv: 1'b1, sgn: 1'b0, hold: 5, exp_data: 16'h1234, exp_ovf: 1'b0};
        vecs[1] = '{res: 16'h0F00, rv: 1'b0, sgn: 1'b1, hold: 1,
                    exp_data: SAT_EN ? 16'h8000 : 16'h0F00, exp_ovf: 1'b1};
        vecs[2] = '{res: 16'h0F00, rv: 1'b0, sgn: 1'b0, hold: 0,
                    exp_data: SAT_EN ? 16'h7FFF : 16'h0F00, exp_ovf: 1'b1};
        vecs[3] = '{res: 16'hFFFF, rv: 1'b1, sgn: 1'b1, hold: 2, exp_data: 16'hFFFF, exp_ovf: 1'b0};
        vecs[4] = '{res: 16'h8000, rv: 1'b0, sgn: 1'b0, hold: 3,
                    exp_data: SAT_EN ? 16'h7FFF : 16'h8000, exp_ovf: 1'b1};

        // Reset state, with in_valid high to confirm acc_en stays gated.
        #12;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_acc_en", 64'(bus.acc_en), 64'(0));
        check("rst_acc_clr", 64'(bus.acc_clr), 64'(0));
        check("rst_qsload", 64'(bus.qsload), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_out_ovf", 64'(bus.out_ovf), 64'(0));
        @(negedge clk); rst = 1'b0; bus.in_valid = 1'b0;

        // len=4, in_valid held high: clr@1, acc_en@2..5, qsload@9, out_valid@10.
        run_txn(4, 100, 0, 16'h00AA, 1'b1, '0, 1'b0, fh, lh, qc, oc, cd, co);
        check("len4_first_hs", 64'(fh), 64'(2));
        check("len4_last_hs", 64'(lh), 64'(5));
        check("len4_qsload", 64'(qc), 64'(9));
        check("len4_out_valid", 64'(oc), 64'(10));

        // len=3, in_valid 1,0,1,0,1 with a stray start mid-ACC.
        run_txn(3, -1, 1, 16'h0042, 1'b1, '0, 1'b1, fh, lh, qc, oc, cd, co);
        check("toggle_last_hs", 64'(lh), 64'(6));
        check("toggle_qsload", 64'(qc), 64'(10));

        for (int i = 0; i < 5; i++) begin
            run_txn(i + 1, 100, vecs[i].hold, vecs[i].res, vecs[i].rv,
                    {vecs[i].sgn, (2*N-1)'($urandom)}, 1'b0, fh, lh, qc, oc, cd, co);
            check($sformatf("vec%0d_data", i), 64'(cd), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_ovf", i), 64'(co), 64'(vecs[i].exp_ovf));
        end

        // start with len=0 is ignored.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.len = '0; bus.in_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            #1;
            if (bus.busy || bus.acc_clr) bad++;
        end
        bus.in_valid = 1'b0;
        check("len0_ignored", 64'(bad), 64'(0));

        // Full count, no wrap.
        run_txn(255, 100, 0, 16'h5A5A, 1'b1, '0, 1'b0, fh, lh, qc, oc, cd, co);
        check("full_last_hs", 64'(lh), 64'(256));

        // Reset mid-ACC after 3 of 5 terms.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.len = LEN_W'(5); bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        hs = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            #1;
            if (bus.acc_en) hs++;
        end
        check("abort_terms_before", 64'(hs), 64'(3));
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_in_ready", 64'(bus.in_ready), 64'(0));
        check("abort_out_valid", 64'(bus.out_valid), 64'(0));
        @(negedge clk); rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            if (bus.qsload || bus.out_valid || bus.busy) bad++;
        end
        bus.in_valid = 1'b0;
        check("abort_no_result", 64'(bad), 64'(0));

        for (int t = 0; t < 30; t++) begin
            run_txn($urandom_range(1, 12), $urandom_range(20, 100), $urandom_range(0, 4),
                    N'($urandom), 1'($urandom_range(0, 1)), (2*N)'($urandom),
                    1'($urandom_range(0, 1)), fh, lh, qc, oc, cd, co);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
